// File: rtl/hdmi_pll_rst_seq.sv
// Reset/lock sequencer for the HDMI clock PLL: pulses the PLL reset, qualifies
// lock, and releases the HDMI pipeline reset only while lock stays qualified.
module hdmi_pll_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock_i,
  output logic             pll_reset_o,
  output logic             hdmi_rst_n_o,
  output logic             ready_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retry_cnt_o,
  output logic [CNT_W-1:0] relock_cnt_o
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                 : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             lock_meta, lock_s;
  logic [CYC_W-1:0] cyc_cnt_q, stable_cnt_q;
  logic [CNT_W-1:0] retry_cnt_q, relock_cnt_q;
  logic             retry_inc, relock_inc, state_chg;

  // Two-flop synchronizer; pll_lock_i is asynchronous to clk.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_s    <= lock_meta;
    end
  end

  // NOTE: every output of this block gets a default first so that no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    retry_inc  = 1'b0;
    relock_inc = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (cyc_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Qualification takes priority over a coincident timeout.
        if (lock_s && (stable_cnt_q == STABLE_LAST)) begin
          state_d = ST_RUN;
        end else if (cyc_cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_PLL_RST;
          retry_inc = 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d    = ST_PLL_RST;
          relock_inc = 1'b1;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
  end

  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PLL_RST;
      cyc_cnt_q    <= '0;
      stable_cnt_q <= '0;
      retry_cnt_q  <= '0;
      relock_cnt_q <= '0;
      pll_reset_o  <= 1'b1;
      hdmi_rst_n_o <= 1'b0;
      ready_o      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_chg) cyc_cnt_q <= '0;
      else           cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);

      // Stable count only advances in WAIT_LOCK and restarts on any low sample.
      if (state_chg || !lock_s || (state_q != ST_WAIT_LOCK)) stable_cnt_q <= '0;
      else                                                   stable_cnt_q <= stable_cnt_q + CYC_W'(1);

      if (retry_inc && (retry_cnt_q != '1))   retry_cnt_q  <= retry_cnt_q + CNT_W'(1);
      if (relock_inc && (relock_cnt_q != '1)) relock_cnt_q <= relock_cnt_q + CNT_W'(1);

      // Outputs are decoded from the next state so they change on the
      // transition edge itself, straight from flops.
      pll_reset_o  <= (state_d == ST_PLL_RST);
      hdmi_rst_n_o <= (state_d == ST_RUN);
      ready_o      <= (state_d == ST_RUN);
    end
  end

  assign state_o      = state_q;
  assign retry_cnt_o  = retry_cnt_q;
  assign relock_cnt_o = relock_cnt_q;

endmodule
